// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : Circular in-order retirement buffer with precise exception flush.
// Revision : 1.0
// ============================================================================
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [31:0]      disp_pc,
  input  logic [4:0]       disp_dest_areg,
  input  logic             disp_has_dest,
  output logic [IDX_W-1:0] disp_rob_idx,
  input  logic             cmpl_valid,
  input  logic [IDX_W-1:0] cmpl_idx,
  input  logic             cmpl_exc,
  output logic             commit_valid,
  input  logic             commit_ready,
  output logic [4:0]       commit_dest_areg,
  output logic             commit_has_dest,
  output logic [31:0]      commit_pc,
  output logic             flush,
  output logic [31:0]      flush_pc,
  output logic [IDX_W:0]   rob_count
);

  localparam logic [IDX_W:0] c_one = {{IDX_W{1'b0}}, 1'b1};

  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_exc;
  logic [ROB_DEPTH-1:0] r_has_dest;
  logic [31:0]          r_pc   [ROB_DEPTH];
  logic [4:0]           r_dest [ROB_DEPTH];

  logic [IDX_W:0]   r_head;
  logic [IDX_W:0]   r_tail;
  logic [IDX_W:0]   r_count;

  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic             w_full;
  logic             w_head_ready;
  logic             w_alloc;
  logic             w_commit;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

  assign w_head_ready = r_valid[w_head_idx] && r_done[w_head_idx];

  // Outputs are gated with rst so a reset never shows a retire or flush pulse.
  assign flush        = w_head_ready && r_exc[w_head_idx] && !rst;
  assign flush_pc     = r_pc[w_head_idx];
  assign commit_valid = w_head_ready && !r_exc[w_head_idx] && !flush && !rst;

  assign commit_pc        = r_pc[w_head_idx];
  assign commit_dest_areg = r_dest[w_head_idx];
  assign commit_has_dest  = r_has_dest[w_head_idx];

  assign disp_ready   = !w_full && !flush;
  assign disp_rob_idx = w_tail_idx;
  assign rob_count    = r_count;

  assign w_alloc  = disp_valid && disp_ready;
  assign w_commit = commit_valid && commit_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_exc   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (cmpl_valid && r_valid[cmpl_idx]) begin
        r_done[cmpl_idx] <= 1'b1;
        r_exc[cmpl_idx]  <= cmpl_exc;
      end
      if (w_alloc) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_exc[w_tail_idx]   <= 1'b0;
        r_tail              <= r_tail + c_one;
      end
      if (w_commit) begin
        r_valid[w_head_idx] <= 1'b0;
        r_head              <= r_head + c_one;
      end
      if (w_alloc && !w_commit) begin
        r_count <= r_count + c_one;
      end else if (!w_alloc && w_commit) begin
        r_count <= r_count - c_one;
      end
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_pc[w_tail_idx]       <= disp_pc;
      r_dest[w_tail_idx]     <= disp_dest_areg;
      r_has_dest[w_tail_idx] <= disp_has_dest;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Purpose  : Directed self-checking bench for reorder_buffer (ROB_DEPTH=16).
// Revision : 1.0
// ============================================================================
module tb_reorder_buffer;

  localparam int c_depth = 16;
  localparam int c_idx_w = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               disp_valid;
  logic               disp_ready;
  logic [31:0]        disp_pc;
  logic [4:0]         disp_dest_areg;
  logic               disp_has_dest;
  logic [c_idx_w-1:0] disp_rob_idx;
  logic               cmpl_valid;
  logic [c_idx_w-1:0] cmpl_idx;
  logic               cmpl_exc;
  logic               commit_valid;
  logic               commit_ready;
  logic [4:0]         commit_dest_areg;
  logic               commit_has_dest;
  logic [31:0]        commit_pc;
  logic               flush;
  logic [31:0]        flush_pc;
  logic [c_idx_w:0]   rob_count;

  int n_cmp = 0;
  int n_err = 0;

  reorder_buffer #(.ROB_DEPTH(c_depth), .IDX_W(c_idx_w)) dut (
    .clk              (clk),
    .rst              (rst),
    .disp_valid       (disp_valid),
    .disp_ready       (disp_ready),
    .disp_pc          (disp_pc),
    .disp_dest_areg   (disp_dest_areg),
    .disp_has_dest    (disp_has_dest),
    .disp_rob_idx     (disp_rob_idx),
    .cmpl_valid       (cmpl_valid),
    .cmpl_idx         (cmpl_idx),
    .cmpl_exc         (cmpl_exc),
    .commit_valid     (commit_valid),
    .commit_ready     (commit_ready),
    .commit_dest_areg (commit_dest_areg),
    .commit_has_dest  (commit_has_dest),
    .commit_pc        (commit_pc),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .rob_count        (rob_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    disp_valid = 1'b0;
    cmpl_valid = 1'b0;
    commit_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic dispatch(input logic [31:0] pc, input logic [4:0] dest);
    disp_valid     = 1'b1;
    disp_pc        = pc;
    disp_dest_areg = dest;
    disp_has_dest  = 1'b1;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic complete(input logic [c_idx_w-1:0] idx, input logic exc);
    cmpl_valid = 1'b1;
    cmpl_idx   = idx;
    cmpl_exc   = exc;
    tick();
    cmpl_valid = 1'b0;
    cmpl_exc   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nc;
    int k;
    int handshakes;
    logic               last_v;
    logic [c_idx_w-1:0] last_i;

    disp_pc = '0; disp_dest_areg = '0; disp_has_dest = 1'b0;
    cmpl_idx = '0; cmpl_exc = 1'b0;
    do_reset();

    check("rst_disp_ready", 32'(disp_ready), 32'd1);
    check("rst_disp_idx", 32'(disp_rob_idx), 32'd0);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_count", 32'(rob_count), 32'd0);

    // In-order retirement with out-of-order completion
    for (int i = 0; i < 3; i++) begin
      check("b_idx", 32'(disp_rob_idx), 32'(i));
      dispatch(32'h100 + 32'(4 * i), 5'(i + 1));
    end
    check("b_count3", 32'(rob_count), 32'd3);
    commit_ready = 1'b1;
    complete(4'd1, 1'b0);
    check("b_no_commit", 32'(commit_valid), 32'd0);
    complete(4'd0, 1'b0);
    check("b_cv0", 32'(commit_valid), 32'd1);
    check("b_pc0", commit_pc, 32'h100);
    check("b_dest0", 32'(commit_dest_areg), 32'd1);
    complete(4'd2, 1'b0);
    check("b_pc1", commit_pc, 32'h104);
    tick();
    check("b_pc2", commit_pc, 32'h108);
    check("b_has_dest2", 32'(commit_has_dest), 32'd1);
    tick();
    check("b_cv_end", 32'(commit_valid), 32'd0);
    check("b_count0", 32'(rob_count), 32'd0);
    commit_ready = 1'b0;

    // Fill to full starting from index 3, then free one slot
    for (int i = 0; i < c_depth; i++) begin
      check("f_ready", 32'(disp_ready), 32'd1);
      dispatch(32'h1000 + 32'(4 * i), 5'd7);
    end
    check("f_full_ready", 32'(disp_ready), 32'd0);
    check("f_count16", 32'(rob_count), 32'd16);
    complete(4'd3, 1'b0);
    commit_ready = 1'b1;
    check("f_cv", 32'(commit_valid), 32'd1);
    check("f_pc", commit_pc, 32'h1000);
    check("f_ready_hold", 32'(disp_ready), 32'd0);
    tick();
    commit_ready = 1'b0;
    check("f_ready_after", 32'(disp_ready), 32'd1);
    check("f_count15", 32'(rob_count), 32'd15);
    do_reset();

    // Streaming 20 entries through, tail wraps 15 -> 0
    nc = 0; k = 0; last_v = 1'b0; last_i = '0;
    commit_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (commit_valid) begin
        check("s_pc", commit_pc, 32'h200 + 32'(4 * nc));
        nc++;
      end
      cmpl_valid = last_v;
      cmpl_idx   = last_i;
      cmpl_exc   = 1'b0;
      if (k < 20) begin
        check("s_idx", 32'(disp_rob_idx), 32'(k % c_depth));
        disp_valid = 1'b1;
        disp_pc    = 32'h200 + 32'(4 * k);
        last_v     = 1'b1;
        last_i     = disp_rob_idx;
        k++;
      end else begin
        disp_valid = 1'b0;
        last_v     = 1'b0;
      end
      tick();
    end
    cmpl_valid = 1'b0;
    check("s_ncommit", 32'(nc), 32'd20);
    check("s_count0", 32'(rob_count), 32'd0);
    do_reset();

    // Exception at idx 1: idx 0 retires, then one-cycle flush
    for (int i = 0; i < 4; i++) dispatch(32'h300 + 32'(4 * i), 5'd3);
    complete(4'd1, 1'b1);
    complete(4'd0, 1'b0);
    commit_ready = 1'b1;
    check("e_cv0", 32'(commit_valid), 32'd1);
    check("e_pc0", commit_pc, 32'h300);
    check("e_noflush", 32'(flush), 32'd0);
    tick();
    disp_valid = 1'b1;
    disp_pc    = 32'h999;
    cmpl_valid = 1'b1;
    cmpl_idx   = 4'd2;
    #1;
    check("e_flush", 32'(flush), 32'd1);
    check("e_flush_pc", flush_pc, 32'h304);
    check("e_cv_flush", 32'(commit_valid), 32'd0);
    check("e_ready_flush", 32'(disp_ready), 32'd0);
    tick();
    disp_valid = 1'b0;
    cmpl_valid = 1'b0;
    check("e_flush_end", 32'(flush), 32'd0);
    check("e_count0", 32'(rob_count), 32'd0);
    check("e_tail0", 32'(disp_rob_idx), 32'd0);
    check("e_cv_after", 32'(commit_valid), 32'd0);

    // Retire back-pressure holds the head
    commit_ready = 1'b0;
    dispatch(32'h400, 5'd9);
    complete(4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("h_cv", 32'(commit_valid), 32'd1);
      check("h_pc", commit_pc, 32'h400);
      tick();
    end
    check("h_count1", 32'(rob_count), 32'd1);
    commit_ready = 1'b1;
    handshakes = 0;
    for (int i = 0; i < 3; i++) begin
      if (commit_valid) handshakes++;
      tick();
    end
    check("h_handshakes", 32'(handshakes), 32'd1);
    check("h_count0", 32'(rob_count), 32'd0);
    commit_ready = 1'b0;

    // Reset with 5 entries in flight, head entry ready to retire
    for (int i = 0; i < 5; i++) dispatch(32'h500 + 32'(4 * i), 5'd4);
    check("r_count5", 32'(rob_count), 32'd5);
    complete(4'd1, 1'b0);
    check("r_cv_pre", 32'(commit_valid), 32'd1);
    commit_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("r_cv_in_rst", 32'(commit_valid), 32'd0);
    check("r_flush_in_rst", 32'(flush), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("r_count0", 32'(rob_count), 32'd0);
    check("r_ready", 32'(disp_ready), 32'd1);
    check("r_idx0", 32'(disp_rob_idx), 32'd0);
    check("r_cv_post", 32'(commit_valid), 32'd0);
    check("r_flush_post", 32'(flush), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
